mem_port_arbiter: RTL

Shares a single-port 16-bit memory between the pipeline's instruction-fetch port and data-memory port, so the CPU can run from one unified memory. Data accesses have priority because they belong to the older instruction. A starvation counter guarantees forward progress for fetch. The block tracks in-flight reads, returns each response to the requester that issued it, and drives a `stall` output that the pipeline uses to freeze IF.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and the arbiter.
// Optional perf-counter port is present only when MEM_ARB_PERF_CNT_EN is defined.
interface mem_port_arbiter_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall
`ifdef MEM_ARB_PERF_CNT_EN
    , output stall_cnt
`endif
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall
`ifdef MEM_ARB_PERF_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins contention until fetch has lost STARVE_LIMIT times in a row.
// Read responses are routed back through a MEM_LATENCY-deep owner tag pipe.
// State updates on the falling clock edge to match the pipeline registers.
// Define MEM_ARB_PERF_CNT_EN to add the saturating stall_cnt output.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic               clock,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_IF   = 2'd1,
    GRANT_DM   = 2'd2
  } grant_e;

  grant_e                      grant;
  logic [CNT_W-1:0]            starve_q;
  logic [CNT_W-1:0]            starve_d;
  logic [ADDR_W-1:0]           sel_addr;
  tag_t                        tag_in;
  tag_t [MEM_LATENCY-1:0]      tag_q;
  tag_t                        tag_out;
  logic                        if_rvalid_q;
  logic                        dm_rvalid_q;
  logic [DATA_W-1:0]           if_rdata_q;
  logic [DATA_W-1:0]           dm_rdata_q;
  logic                        stall_c;

  // Pick the winner for this cycle: data first unless fetch is starving
  always_comb begin
    grant = GRANT_NONE;
    if (bus.dm_req && (!bus.if_req || (starve_q < LIMIT))) begin
      grant = GRANT_DM;
    end else if (bus.if_req) begin
      grant = GRANT_IF;
    end
  end

  // Drive the memory port and grants from the winner; all zero when idle
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    sel_addr      = '0;
    tag_in        = '0;
    case (grant)
      GRANT_IF: begin
        bus.if_gnt   = 1'b1;
        bus.mem_en   = 1'b1;
        sel_addr     = bus.if_addr;
        tag_in.valid = 1'b1;
        tag_in.owner = OWNER_IF;
      end
      GRANT_DM: begin
        bus.dm_gnt    = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.dm_we;
        bus.mem_wdata = bus.dm_wdata;
        sel_addr      = bus.dm_addr;
        tag_in.valid  = ~bus.dm_we;
        tag_in.owner  = OWNER_DM;
      end
      default: ;
    endcase
    bus.mem_addr = sel_addr >> 1;
  end

  assign stall_c   = bus.if_req & ~bus.if_gnt;
  assign bus.stall = stall_c;

  // Next starvation count: cleared when fetch wins or stops asking
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || (grant == GRANT_IF)) begin
      starve_d = '0;
    end else if ((grant == GRANT_DM) && (starve_q < LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Owner tag pipe, one entry per cycle, aligned with memory read latency
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[MEM_LATENCY-1];

  // Route the returning read to its owner; the other port keeps its data
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= tag_out.valid && (tag_out.owner == OWNER_IF);
      dm_rvalid_q <= tag_out.valid && (tag_out.owner == OWNER_DM);
      if (tag_out.valid && (tag_out.owner == OWNER_IF)) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (tag_out.valid && (tag_out.owner == OWNER_DM)) begin
        dm_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of fetch stall cycles
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
